// File: rtl/pauli_y_core.sv
// Single-amplitude Pauli-Y engine: flips masked qubits of the basis index and
// applies the accumulated i^k phase to the complex amplitude, one register stage.
module pauli_y_core #(
  parameter int unsigned AMP_WIDTH = 32,
  parameter int unsigned N_QUBIT   = 5
) (
  input  logic                        clk,
  input  logic                        aclr,
  input  logic                        clk_en,
  input  logic                        en,
  input  logic signed [AMP_WIDTH-1:0] amp_in_real,
  input  logic signed [AMP_WIDTH-1:0] amp_in_img,
  input  logic        [N_QUBIT-1:0]   qubit_op,
  input  logic        [N_QUBIT-1:0]   state_in,
  output logic signed [AMP_WIDTH-1:0] amp_out_real,
  output logic signed [AMP_WIDTH-1:0] amp_out_img,
  output logic        [N_QUBIT-1:0]   state_out
);

  logic        [1:0]           phase_c;
  logic signed [AMP_WIDTH-1:0] neg_real_c;
  logic signed [AMP_WIDTH-1:0] neg_img_c;
  logic signed [AMP_WIDTH-1:0] res_real_c;
  logic signed [AMP_WIDTH-1:0] res_img_c;

  // Mod-4 phase: each masked |0> contributes i, each masked |1> contributes -i = i^3.
  always_comb begin
    phase_c = 2'd0;
    for (int unsigned q = 0; q < N_QUBIT; q++) begin
      if (qubit_op[q]) begin
        phase_c = phase_c + (state_in[q] ? 2'd3 : 2'd1);
      end
    end
  end

  // Two's-complement wrap: the most negative value maps onto itself.
  assign neg_real_c = -amp_in_real;
  assign neg_img_c  = -amp_in_img;

  always_comb begin
    res_real_c = amp_in_real;
    res_img_c  = amp_in_img;
    case (phase_c)
      2'd1: begin
        res_real_c = neg_img_c;
        res_img_c  = amp_in_real;
      end
      2'd2: begin
        res_real_c = neg_real_c;
        res_img_c  = neg_img_c;
      end
      2'd3: begin
        res_real_c = amp_in_img;
        res_img_c  = neg_real_c;
      end
      default: begin
        res_real_c = amp_in_real;
        res_img_c  = amp_in_img;
      end
    endcase
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      amp_out_real <= '0;
      amp_out_img  <= '0;
      state_out    <= '0;
    end else if (clk_en && en) begin
      amp_out_real <= res_real_c;
      amp_out_img  <= res_img_c;
      state_out    <= state_in ^ qubit_op;
    end
  end

endmodule

// File: tb/tb_pauli_y_core.sv
// Scoreboard bench for pauli_y_core: expected results are queued when stimulus is
// driven and popped once the registered outputs should reflect them.
module tb_pauli_y_core;

  localparam int unsigned W  = 32;
  localparam int unsigned N  = 5;
  localparam int unsigned RW = 2 * W + N;

  logic                clk = 1'b0;
  logic                aclr;
  logic                clk_en;
  logic                en;
  logic signed [W-1:0] amp_in_real;
  logic signed [W-1:0] amp_in_img;
  logic        [N-1:0] qubit_op;
  logic        [N-1:0] state_in;
  logic signed [W-1:0] amp_out_real;
  logic signed [W-1:0] amp_out_img;
  logic        [N-1:0] state_out;

  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] got;
  logic [RW-1:0] want;
  logic [RW-1:0] last;
  int n_checks = 0;
  int n_fail   = 0;

  pauli_y_core #(.AMP_WIDTH(W), .N_QUBIT(N)) dut (
    .clk(clk), .aclr(aclr), .clk_en(clk_en), .en(en),
    .amp_in_real(amp_in_real), .amp_in_img(amp_in_img),
    .qubit_op(qubit_op), .state_in(state_in),
    .amp_out_real(amp_out_real), .amp_out_img(amp_out_img), .state_out(state_out)
  );

  always #5 clk = ~clk;

  // Reference: count phases independently, then rotate by i one step at a time.
  function automatic logic [RW-1:0] model(input logic [N-1:0] op, input logic [N-1:0] st,
                                          input logic [W-1:0] re, input logic [W-1:0] im);
    int n0, n1, k;
    logic [W-1:0] r, i, t;
    n0 = $countones(op & ~st);
    n1 = $countones(op & st);
    k  = (n0 + 3 * n1) % 4;
    r = re;
    i = im;
    for (int s = 0; s < k; s++) begin
      t = r;
      r = -i;
      i = t;
    end
    return {r, i, op ^ st};
  endfunction

  task automatic drive(input logic [N-1:0] op, input logic [N-1:0] st,
                       input logic [W-1:0] re, input logic [W-1:0] im,
                       input logic en_v, input logic ce_v);
    @(negedge clk);
    qubit_op    = op;
    state_in    = st;
    amp_in_real = re;
    amp_in_img  = im;
    en          = en_v;
    clk_en      = ce_v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    aclr = 1'b1; clk_en = 1'b1; en = 1'b1;
    qubit_op = 5'b10101; state_in = 5'b00111;
    amp_in_real = 32'h1111_2222; amp_in_img = 32'h3333_4444;
    repeat (2) @(posedge clk);
    #1;
    got = {amp_out_real, amp_out_img, state_out};
    n_checks++;
    if (got !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got %h required 0", got);
    end
    @(negedge clk);
    aclr = 1'b0;
  endtask

  task automatic test_spec_vectors();
    logic [N-1:0] ops[4];
    logic [N-1:0] sts[4];
    logic [W-1:0] res[4];
    logic [W-1:0] ims[4];
    ops[0] = 5'b10011; sts[0] = 5'b00100; res[0] = 32'hFFC98E0F; ims[0] = 32'h2EFBA141;
    ops[1] = 5'b00011; sts[1] = 5'b11100; res[1] = 32'hE6E7F72D; ims[1] = 32'h9383D9D9;
    ops[2] = 5'b00100; sts[2] = 5'b10101; res[2] = 32'hF183A344; ims[2] = 32'h1C89BFE7;
    ops[3] = 5'b00001; sts[3] = 5'b01011; res[3] = 32'hF183A344; ims[3] = 32'h1C89BFE7;
    exp_q.push_back({32'h2EFBA141, 32'h003671F1, 5'b10111});
    exp_q.push_back({32'h191808D3, 32'h6C7C2627, 5'b11111});
    exp_q.push_back({32'h1C89BFE7, 32'h0E7C5CBC, 5'b10001});
    exp_q.push_back({32'h1C89BFE7, 32'h0E7C5CBC, 5'b01010});
    for (int v = 0; v < 4; v++) begin
      drive(ops[v], sts[v], res[v], ims[v], 1'b1, 1'b1);
      got = {amp_out_real, amp_out_img, state_out};
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL spec_vector_%0d: got %h required %h", v, got, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] op, st;
    logic [W-1:0] re, im;
    for (int v = 0; v < 10; v++) begin
      op = N'($urandom); st = N'($urandom); re = $urandom; im = $urandom;
      exp_q.push_back(model(op, st, re, im));
      drive(op, st, re, im, 1'b1, 1'b1);
      got = {amp_out_real, amp_out_img, state_out};
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL b2b_queue_empty: got %h required a queued value", got);
      end else begin
        want = exp_q.pop_front();
        last = want;
        n_checks++;
        if (got !== want) begin
          n_fail++;
          $display("FAIL b2b_%0d: got %h required %h", v, got, want);
        end
      end
    end
    // en low with clock enabled: outputs hold while inputs keep moving.
    for (int c = 0; c < 4; c++) begin
      drive(N'($urandom), N'($urandom), $urandom, $urandom, 1'b0, 1'b1);
      got = {amp_out_real, amp_out_img, state_out};
      n_checks++;
      if (got !== last) begin
        n_fail++;
        $display("FAIL hold_en_low_%0d: got %h required %h", c, got, last);
      end
    end
    // clk_en low overrides en.
    for (int c = 0; c < 3; c++) begin
      drive(5'b11111, N'($urandom), $urandom, $urandom, 1'b1, 1'b0);
      got = {amp_out_real, amp_out_img, state_out};
      n_checks++;
      if (got !== last) begin
        n_fail++;
        $display("FAIL hold_clk_en_low_%0d: got %h required %h", c, got, last);
      end
    end
  endtask

  task automatic test_passthrough_wrap();
    exp_q.push_back({32'h12345678, 32'h9ABCDEF0, 5'b10101});
    drive(5'b00000, 5'b10101, 32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b1);
    got = {amp_out_real, amp_out_img, state_out};
    want = exp_q.pop_front();
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL passthrough: got %h required %h", got, want);
    end
    exp_q.push_back({32'h80000000, 32'hFFFFFFFF, 5'b00011});
    drive(5'b00011, 5'b00000, 32'h80000000, 32'h00000001, 1'b1, 1'b1);
    got = {amp_out_real, amp_out_img, state_out};
    want = exp_q.pop_front();
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL negate_wrap: got %h required %h", got, want);
    end
  endtask

  task automatic test_async_clear();
    exp_q.push_back(model(5'b01010, 5'b00110, 32'h0BADF00D, 32'h7EEDBEEF));
    drive(5'b01010, 5'b00110, 32'h0BADF00D, 32'h7EEDBEEF, 1'b1, 1'b1);
    got = {amp_out_real, amp_out_img, state_out};
    want = exp_q.pop_front();
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL pre_clear_load: got %h required %h", got, want);
    end
    #2;
    aclr = 1'b1;
    #1;
    got = {amp_out_real, amp_out_img, state_out};
    n_checks++;
    if (got !== '0) begin
      n_fail++;
      $display("FAIL async_clear: got %h required 0", got);
    end
    for (int c = 0; c < 2; c++) begin
      drive(5'b11001, 5'b00101, $urandom, $urandom, 1'b1, 1'b1);
      got = {amp_out_real, amp_out_img, state_out};
      n_checks++;
      if (got !== '0) begin
        n_fail++;
        $display("FAIL clear_held_%0d: got %h required 0", c, got);
      end
    end
    @(negedge clk);
    aclr = 1'b0;
    exp_q.push_back(model(5'b00110, 5'b10010, 32'hCAFE0001, 32'h00C0FFEE));
    drive(5'b00110, 5'b10010, 32'hCAFE0001, 32'h00C0FFEE, 1'b1, 1'b1);
    got = {amp_out_real, amp_out_img, state_out};
    want = exp_q.pop_front();
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL post_clear_load: got %h required %h", got, want);
    end
  endtask

  initial begin
    test_reset();
    test_spec_vectors();
    test_back_to_back();
    test_passthrough_wrap();
    test_async_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/pauli_y_core.md
# pauli_y_core

Single-amplitude Pauli-Y gate engine for the state-vector quantum simulator datapath. Each cycle it takes one basis-state index and its complex amplitude, and applies Y to every qubit selected in a bit mask. It outputs the transformed amplitude and the destination basis-state index through one register stage. It sits between the amplitude memory read port and the write-back stage.

## Interface
- AMP_WIDTH, default 32: width of each signed two's-complement amplitude component (real and imaginary).
- N_QUBIT, default 5: number of qubits; width of the state index and qubit mask.

- clk  input  1  system clock; all state changes on the rising edge.
- aclr  input  1  reset, asynchronous and active-high; clears all output registers.
- clk_en  input  1  global clock enable; when 0 the block holds all state.
- en  input  1  operation enable; a new result is loaded only when clk_en=1 and en=1.
- amp_in_real  input  AMP_WIDTH  signed real part of the input amplitude.
- amp_in_img  input  AMP_WIDTH  signed imaginary part of the input amplitude.
- qubit_op  input  N_QUBIT  mask; bit q=1 applies Y to qubit q.
- state_in  input  N_QUBIT  basis-state index of the input amplitude; bit q is qubit q.
- amp_out_real  output  AMP_WIDTH  signed real part of the result (registered).
- amp_out_img  output  AMP_WIDTH  signed imaginary part of the result (registered).
- state_out  output  N_QUBIT  destination basis-state index (registered).

## Operation
- Y|0> = i|1> and Y|1> = -i|0>, applied independently to each masked qubit.
- Destination index: state_out = state_in XOR qubit_op.
- Phase count:
  - n0 = number of bits with qubit_op=1 and state_in=0.
  - n1 = number of bits with qubit_op=1 and state_in=1.
  - k = (n0 + 3*n1) mod 4, so the total phase is i^k.
- Amplitude mapping, with a = amp_in_real and b = amp_in_img:
  - k=0: (a, b)
  - k=1: (-b, a)
  - k=2: (-a, -b)
  - k=3: (b, -a)
- Negation is two's-complement and truncated to AMP_WIDTH with no saturation. The most negative value, -2^(AMP_WIDTH-1), negates to itself.
- qubit_op=0 gives k=0: the amplitude and index pass through unchanged.
- The combinational path is: popcount (or an equivalent mod-4 reduction) of the masked bits, a 4-way select, and conditional negation. The output registers follow it.

## Timing
- Latency is 1 cycle. Inputs sampled at rising edge t (with clk_en=1 and en=1) appear on the outputs immediately after edge t.
- With clk_en=1 and en=0, the outputs hold their previous values. With clk_en=0, the outputs hold regardless of en.
- Throughput is one amplitude per cycle; there is no handshake and no backpressure.
- aclr=1 immediately (asynchronously) forces amp_out_real=0, amp_out_img=0 and state_out=0.
  - The outputs stay 0 while aclr is held, even if en=1 and clk_en=1.
  - After aclr falls, the next qualifying edge loads a new result normally.
- The reset value of every output is 0.
- Inputs are sampled only at the edge; mid-cycle changes have no effect.

## Test plan
- qubit_op=10011, state_in=00100, real=0xFFC98E0F, img=0x2EFBA141, en=1 -> next cycle: state_out=10111, k=3, real=0x2EFBA141, img=0x003671F1.
- qubit_op=00011, state_in=11100, real=0xE6E7F72D, img=0x9383D9D9 -> state_out=11111, k=2, real=0x191808D3, img=0x6C7C2627.
- qubit_op=00100, state_in=10101, real=0xF183A344, img=0x1C89BFE7 -> state_out=10001, k=3, real=0x1C89BFE7, img=0x0E7C5CBC. Then present qubit_op=00001, state_in=01011 -> state_out=01010, k=3.
- Back-to-back inputs with en=1 on every cycle -> one result per cycle, each exactly 1 cycle later. Then drop en to 0 with clk_en=1 -> outputs hold the last result for 3+ cycles.
- qubit_op=00000, state_in=10101, a=0x12345678 -> outputs equal the inputs. Then input real=0x80000000 with k=2 -> real=0x80000000 (wraps to itself).
- Assert aclr between clock edges while outputs are nonzero -> all outputs go to 0 before the next edge and stay 0 while aclr=1 with en=1. Deassert aclr -> the next qualifying edge loads normally.
